// File: rtl/pwl_pkg.sv
// pwl_pkg: shared definitions for the piecewise-linear evaluator.
//   - pwl_state_e  : controller states
//   - cfg_sel_e    : table select codes for the configuration port
//   - sm_less_than : ordering of sign-magnitude words (-0 sorts below +0)
// No ports; imported by pwl_coef_table and pwl_eval_ctrl.
package pwl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_MUL,
    ST_ADD,
    ST_OUT
  } pwl_state_e;

  typedef enum logic [1:0] {
    CFG_SEL_BP   = 2'd0,
    CFG_SEL_M    = 2'd1,
    CFG_SEL_C    = 2'd2,
    CFG_SEL_NONE = 2'd3
  } cfg_sel_e;

  // Magnitudes are zero-extended to this width so one function serves any DW <= 64.
  localparam int unsigned SM_MAG_W = 63;

  // Sign-magnitude strict less-than. Differing signs: the negative operand is
  // smaller, which also places -0 below +0. Same sign: compare magnitudes,
  // with the sense reversed for negatives. Equal words are never less-than.
  function automatic logic sm_less_than(input logic                a_sign,
                                        input logic [SM_MAG_W-1:0] a_mag,
                                        input logic                b_sign,
                                        input logic [SM_MAG_W-1:0] b_mag);
    logic lt;
    if (a_sign != b_sign) begin
      lt = a_sign;
    end else if (!a_sign) begin
      lt = (a_mag < b_mag);
    end else begin
      lt = (a_mag > b_mag);
    end
    return lt;
  endfunction

endpackage

// File: rtl/pwl_coef_table.sv
// pwl_coef_table: breakpoint, slope and intercept storage for pwl_eval_ctrl.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (clears every entry)
//   we_i, sel_i          write strobe (already qualified by the controller), target table
//   addr_i, wdata_i      entry index and write value; indices past a table's end are dropped
//   bp_idx_i, bp_o       combinational breakpoint read (NBP entries)
//   coef_idx_i, m_o, c_o combinational slope / intercept read (NBP+1 entries)
module pwl_coef_table
  import pwl_pkg::*;
#(
  parameter int DW  = 32,
  parameter int NBP = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [1:0]    sel_i,
  input  logic [3:0]    addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [3:0]    bp_idx_i,
  input  logic [3:0]    coef_idx_i,
  output logic [DW-1:0] bp_o,
  output logic [DW-1:0] m_o,
  output logic [DW-1:0] c_o
);

  logic [DW-1:0] bp_q [NBP];
  logic [DW-1:0] m_q  [NBP+1];
  logic [DW-1:0] c_q  [NBP+1];

  // Writes decode the address by comparing against each entry index, so an
  // address beyond the selected table simply matches nothing and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBP; i++) begin
        bp_q[i] <= '0;
      end
      for (int i = 0; i <= NBP; i++) begin
        m_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else if (we_i) begin
      case (sel_i)
        CFG_SEL_BP: begin
          for (int i = 0; i < NBP; i++) begin
            if (addr_i == 4'(i)) bp_q[i] <= wdata_i;
          end
        end
        CFG_SEL_M: begin
          for (int i = 0; i <= NBP; i++) begin
            if (addr_i == 4'(i)) m_q[i] <= wdata_i;
          end
        end
        CFG_SEL_C: begin
          for (int i = 0; i <= NBP; i++) begin
            if (addr_i == 4'(i)) c_q[i] <= wdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational read muxes; an out-of-range index reads as zero.
  always_comb begin
    bp_o = '0;
    m_o  = '0;
    c_o  = '0;
    for (int i = 0; i < NBP; i++) begin
      if (bp_idx_i == 4'(i)) bp_o = bp_q[i];
    end
    for (int i = 0; i <= NBP; i++) begin
      if (coef_idx_i == 4'(i)) begin
        m_o = m_q[i];
        c_o = c_q[i];
      end
    end
  end

endmodule

// File: rtl/pwl_eval_ctrl.sv
// pwl_eval_ctrl: piecewise-linear evaluator y = m[r]*x + c[r], where region r is
// the first breakpoint index with x < bp[r] (NBP when none matches). The
// multiply and add are delegated to shared FP units over req/ack ports.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data        operand handshake (accepted only in IDLE)
//   out_valid/out_ready/out_data     result handshake, out_region = selected region
//   cfg_we/cfg_sel/cfg_addr/cfg_wdata/cfg_ready  table write port, open only in IDLE
//   mul_req/mul_a/mul_b/mul_ack/mul_res          shared multiplier port
//   add_req/add_a/add_b/add_ack/add_res          shared adder port
//   busy                             high whenever not IDLE
// Build option: define PWL_SAT_SKIP_EN to bypass MUL/ADD for the two outer
// regions when their slope magnitude is zero (result is the intercept).
module pwl_eval_ctrl
  import pwl_pkg::*;
#(
  parameter int DW  = 32,
  parameter int NBP = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_region,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [3:0]    cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  output logic          cfg_ready,
  output logic          mul_req,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  input  logic          mul_ack,
  input  logic [DW-1:0] mul_res,
  output logic          add_req,
  output logic [DW-1:0] add_a,
  output logic [DW-1:0] add_b,
  input  logic          add_ack,
  input  logic [DW-1:0] add_res,
  output logic          busy
);

  localparam logic [3:0] LAST_IDX   = 4'(NBP - 1);
  localparam logic [3:0] REGION_MAX = 4'(NBP);

  pwl_state_e    state_q, state_d;
  logic [DW-1:0] x_q;
  logic [3:0]    idx_q;
  logic [3:0]    region_q;
  logic [DW-1:0] prod_q;
  logic [DW-1:0] out_data_q;

  logic [DW-1:0] bp_rd, m_rd, c_rd;
  logic [3:0]    coef_idx;
  logic          x_lt_bp;
  logic          search_done;
  logic [3:0]    search_region;
  logic          sat_skip;

  pwl_coef_table #(
    .DW  (DW),
    .NBP (NBP)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (cfg_we && cfg_ready),
    .sel_i      (cfg_sel),
    .addr_i     (cfg_addr),
    .wdata_i    (cfg_wdata),
    .bp_idx_i   (idx_q),
    .coef_idx_i (coef_idx),
    .bp_o       (bp_rd),
    .m_o        (m_rd),
    .c_o        (c_rd)
  );

  assign x_lt_bp       = sm_less_than(x_q[DW-1],   SM_MAG_W'(x_q[DW-2:0]),
                                      bp_rd[DW-1], SM_MAG_W'(bp_rd[DW-2:0]));
  assign search_done   = x_lt_bp || (idx_q == LAST_IDX);
  assign search_region = x_lt_bp ? idx_q : REGION_MAX;

  // During SEARCH the coefficients are read at the candidate region so the
  // saturation bypass can load the intercept in the same cycle the search ends.
  assign coef_idx = (state_q == ST_SEARCH) ? search_region : region_q;

`ifdef PWL_SAT_SKIP_EN
  assign sat_skip = ((search_region == 4'd0) || (search_region == REGION_MAX)) &&
                    (m_rd[DW-2:0] == '0);
`else
  assign sat_skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (in_valid)  state_d = ST_SEARCH;
      ST_SEARCH: if (search_done) state_d = sat_skip ? ST_OUT : ST_MUL;
      ST_MUL:    if (mul_ack)   state_d = ST_ADD;
      ST_ADD:    if (add_ack)   state_d = ST_OUT;
      ST_OUT:    if (out_ready) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers; acks are only honoured in their own state, so a
  // stray ack after reset lands in IDLE and changes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      idx_q      <= '0;
      region_q   <= '0;
      prod_q     <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q   <= in_data;
            idx_q <= '0;
          end
        end
        ST_SEARCH: begin
          if (search_done) begin
            region_q <= search_region;
            if (sat_skip) out_data_q <= c_rd;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        ST_MUL: if (mul_ack) prod_q <= mul_res;
        ST_ADD: if (add_ack) out_data_q <= add_res;
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    mul_req   = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    add_req   = 1'b0;
    add_a     = '0;
    add_b     = '0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
      end
      ST_MUL: begin
        mul_req = 1'b1;
        mul_a   = m_rd;
        mul_b   = x_q;
      end
      ST_ADD: begin
        add_req = 1'b1;
        add_a   = prod_q;
        add_b   = c_rd;
      end
      ST_OUT: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign out_data   = out_data_q;
  assign out_region = region_q;

endmodule

// File: tb/tb_pwl_eval_ctrl.sv
// tb_pwl_eval_ctrl: self-checking bench for pwl_eval_ctrl. The bench plays the
// shared multiplier/adder, keeps its own copy of the tables, and predicts the
// region by mapping each sign-magnitude word onto a signed integer key that
// preserves the required ordering (-0 just below +0).
module tb_pwl_eval_ctrl;

  localparam int DW  = 32;
  localparam int NBP = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    out_region;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [3:0]    cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_ready;
  logic          mul_req, mul_ack;
  logic [DW-1:0] mul_a, mul_b, mul_res;
  logic          add_req, add_ack;
  logic [DW-1:0] add_a, add_b, add_res;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] bpModel [NBP];
  logic [DW-1:0] mModel  [NBP+1];
  logic [DW-1:0] cModel  [NBP+1];

  pwl_eval_ctrl #(.DW(DW), .NBP(NBP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_region(out_region),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_res(mul_res),
    .add_req(add_req), .add_a(add_a), .add_b(add_b), .add_ack(add_ack), .add_res(add_res),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation time exceeded got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Ordering key: positives map to their magnitude, negatives to -(mag)-1.
  function automatic longint smKey(input logic [31:0] v);
    longint mag;
    mag = 0;
    mag[30:0] = v[30:0];
    return v[31] ? (-mag - 1) : mag;
  endfunction

  function automatic int modelRegion(input logic [31:0] x);
    for (int i = 0; i < NBP; i++) begin
      if (smKey(x) < smKey(bpModel[i])) return i;
    end
    return NBP;
  endfunction

  function automatic bit modelSkip(input int region);
`ifdef PWL_SAT_SKIP_EN
    return ((region == 0) || (region == NBP)) && (mModel[region][30:0] == 31'd0);
`else
    return (region < 0);
`endif
  endfunction

  task automatic modelClear();
    for (int i = 0; i < NBP; i++) bpModel[i] = '0;
    for (int i = 0; i <= NBP; i++) begin
      mModel[i] = '0;
      cModel[i] = '0;
    end
  endtask

  task automatic modelWrite(input logic [1:0] sel, input logic [3:0] addr, input logic [31:0] data);
    int a;
    a = int'(addr);
    if (sel == 2'd0 && a < NBP)  bpModel[a] = data;
    if (sel == 2'd1 && a <= NBP) mModel[a]  = data;
    if (sel == 2'd2 && a <= NBP) cModel[a]  = data;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cfg_ready_idle got=%b exp=1", cfg_ready);
    end
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
    modelWrite(sel, addr, data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  function automatic logic [31:0] randFloat();
    logic [31:0] f;
    f = $urandom;
    f[30:23] = 8'(124 + $urandom_range(0, 5));
    return f;
  endfunction

  // Drives one complete operation and checks every visible step against the model.
  task automatic run_op(input logic [31:0] x, input int mulDly, input int addDly, input int outDly,
                        input bit cfgInMul, input bit cfgSame,
                        input logic [1:0] cSel, input logic [3:0] cAddr, input logic [31:0] cData);
    int region, lat, cnt;
    bit skip;
    logic [31:0] mres, ares, expOut;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_ready got in_ready=%b busy=%b exp in_ready=1 busy=0", in_ready, busy);
    end
    in_valid = 1'b1;
    in_data  = x;
    if (cfgSame) begin
      cfg_we = 1'b1; cfg_sel = cSel; cfg_addr = cAddr; cfg_wdata = cData;
      modelWrite(cSel, cAddr, cData);
    end
    region = modelRegion(x);
    lat    = (region + 1 > NBP) ? NBP : region + 1;
    skip   = modelSkip(region);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    in_data  = $urandom;
    cnt = 0;
    while (mul_req !== 1'b1 && out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt != lat) begin
      failures++;
      $display("[TB] FAIL search_latency x=%h got=%0d exp=%0d", x, cnt, lat);
    end
    checks++;
    if (out_region !== 4'(region)) begin
      failures++;
      $display("[TB] FAIL region x=%h got=%0d exp=%0d", x, out_region, region);
    end
    if (skip) begin
      checks++;
      if (out_valid !== 1'b1 || mul_req !== 1'b0) begin
        failures++;
        $display("[TB] FAIL sat_skip_path got out_valid=%b mul_req=%b exp 1/0", out_valid, mul_req);
      end
      expOut = cModel[region];
    end else begin
      checks++;
      if (mul_req !== 1'b1 || busy !== 1'b1 || mul_a !== mModel[region] || mul_b !== x) begin
        failures++;
        $display("[TB] FAIL mul_operands got req=%b a=%h b=%h exp req=1 a=%h b=%h",
                 mul_req, mul_a, mul_b, mModel[region], x);
      end
      if (cfgInMul) begin
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_addr = 4'(region); cfg_wdata = ~mModel[region];
        checks++;
        if (cfg_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL cfg_ready_busy got=%b exp=0", cfg_ready);
        end
      end
      for (int i = 0; i < mulDly; i++) begin
        @(negedge clk);
        cfg_we = 1'b0;
        checks++;
        if (mul_req !== 1'b1 || mul_a !== mModel[region] || mul_b !== x || in_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL mul_hold got req=%b a=%h b=%h in_ready=%b exp req=1 a=%h b=%h in_ready=0",
                   mul_req, mul_a, mul_b, in_ready, mModel[region], x);
        end
      end
      mres = $urandom;
      mul_ack = 1'b1; mul_res = mres;
      @(negedge clk);
      mul_ack = 1'b0; cfg_we = 1'b0; mul_res = $urandom;
      checks++;
      if (mul_req !== 1'b0 || add_req !== 1'b1) begin
        failures++;
        $display("[TB] FAIL mul_handoff got mul_req=%b add_req=%b exp 0/1", mul_req, add_req);
      end
      checks++;
      if (add_a !== mres || add_b !== cModel[region]) begin
        failures++;
        $display("[TB] FAIL add_operands got a=%h b=%h exp a=%h b=%h", add_a, add_b, mres, cModel[region]);
      end
      for (int i = 0; i < addDly; i++) begin
        @(negedge clk);
        checks++;
        if (add_req !== 1'b1 || add_a !== mres || add_b !== cModel[region]) begin
          failures++;
          $display("[TB] FAIL add_hold got req=%b a=%h b=%h exp req=1 a=%h b=%h",
                   add_req, add_a, add_b, mres, cModel[region]);
        end
      end
      ares = $urandom;
      add_ack = 1'b1; add_res = ares;
      @(negedge clk);
      add_ack = 1'b0; add_res = $urandom;
      checks++;
      if (add_req !== 1'b0) begin
        failures++;
        $display("[TB] FAIL add_release got=%b exp=0", add_req);
      end
      expOut = ares;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== expOut || out_region !== 4'(region)) begin
      failures++;
      $display("[TB] FAIL out_result got valid=%b data=%h region=%0d exp valid=1 data=%h region=%0d",
               out_valid, out_data, out_region, expOut, region);
    end
    for (int i = 0; i < outDly; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== expOut || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL out_hold got valid=%b data=%h in_ready=%b exp valid=1 data=%h in_ready=0",
                 out_valid, out_data, in_ready, expOut);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL out_release got valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic load_directed_tables();
    logic [31:0] bpVals [NBP];
    bpVals = '{32'hC0400000, 32'hC0000000, 32'hBF800000, 32'hBF000000,
               32'h3F000000, 32'h3F800000, 32'h40000000, 32'h40400000};
    for (int i = 0; i < NBP; i++) cfg_write(2'd0, 4'(i), bpVals[i]);
    for (int i = 0; i <= NBP; i++) begin
      cfg_write(2'd1, 4'(i), $urandom | 32'h00800000);
      cfg_write(2'd2, 4'(i), $urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_data = '0; out_ready = 0; cfg_we = 0; cfg_sel = '0; cfg_addr = '0;
    cfg_wdata = '0; mul_ack = 0; mul_res = '0; add_ack = 0; add_res = '0;
    modelClear();
    #13;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_req !== 1'b0 || add_req !== 1'b0 ||
        busy !== 1'b0 || cfg_ready !== 1'b1 || out_data !== '0 || out_region !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_values got in_ready=%b out_valid=%b mul_req=%b add_req=%b busy=%b cfg_ready=%b out_data=%h out_region=%0d exp 1/0/0/0/0/1/0/0",
               in_ready, out_valid, mul_req, add_req, busy, cfg_ready, out_data, out_region);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hBF800000, 0, 0, 0, 0, 0, 2'd0, 4'd0, '0);
  endtask

  task automatic test_directed();
    load_directed_tables();
    run_op(32'hC0800000, 0, 0, 0, 0, 0, 2'd0, 4'd0, '0);
    run_op(32'h00000000, 1, 1, 1, 0, 0, 2'd0, 4'd0, '0);
    run_op(32'h80000000, 0, 2, 0, 0, 0, 2'd0, 4'd0, '0);
    run_op(32'h40400000, 0, 0, 0, 0, 0, 2'd0, 4'd0, '0);
    run_op(32'h3F000000, 5, 0, 3, 0, 0, 2'd0, 4'd0, '0);
  endtask

  task automatic test_cfg_guard();
    run_op(32'h3F400000, 3, 0, 0, 1, 0, 2'd0, 4'd0, '0);
    run_op(32'h3F400000, 2, 0, 0, 0, 0, 2'd0, 4'd0, '0);
  endtask

  task automatic test_same_cycle();
    run_op(32'hC0800000, 0, 0, 0, 0, 1, 2'd0, 4'd0, 32'hC1000000);
  endtask

  task automatic test_out_of_range();
    cfg_write(2'd3, 4'd0, 32'hC1200000);
    cfg_write(2'd0, 4'd8, 32'hC1200000);
    cfg_write(2'd1, 4'd9, 32'h12345678);
    cfg_write(2'd2, 4'd15, 32'h12345678);
    run_op(32'hC1100000, 1, 0, 0, 0, 0, 2'd0, 4'd0, '0);
    run_op(32'h41200000, 0, 0, 0, 0, 0, 2'd0, 4'd0, '0);
  endtask

  task automatic test_random();
    logic [31:0] x;
    for (int n = 0; n < 20; n++) begin
      if (n % 4 == 3) begin
        cfg_write(2'd0, 4'($urandom_range(0, NBP - 1)), randFloat());
        cfg_write(2'd1, 4'($urandom_range(0, NBP)), ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom);
        cfg_write(2'd2, 4'($urandom_range(0, NBP)), $urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        x = bpModel[$urandom_range(0, NBP - 1)];
        if ($urandom_range(0, 3) == 0) x[31] = ~x[31];
      end else begin
        x = randFloat();
      end
      run_op(x, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 2'd0, 4'd0, '0);
    end
  endtask

  task automatic test_sat_skip();
    load_directed_tables();
    cfg_write(2'd1, 4'd8, 32'h00000000);
    cfg_write(2'd2, 4'd8, 32'h3F800000);
    run_op(32'h41200000, 1, 1, 1, 0, 0, 2'd0, 4'd0, '0);
    cfg_write(2'd1, 4'd0, 32'h80000000);
    run_op(32'hC0800000, 0, 0, 0, 0, 0, 2'd0, 4'd0, '0);
    run_op(32'h3F400000, 0, 0, 0, 0, 0, 2'd0, 4'd0, '0);
  endtask

  task automatic test_reset_mid();
    int cnt;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h3F400000;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (mul_req !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    mul_ack = 1'b1; mul_res = $urandom;
    @(negedge clk);
    mul_ack = 1'b0;
    checks++;
    if (add_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_reach_add got=%b exp=1", add_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (add_req !== 1'b0 || mul_req !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        cfg_ready !== 1'b1 || out_data !== '0 || out_region !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs got add_req=%b busy=%b in_ready=%b out_valid=%b cfg_ready=%b out_data=%h out_region=%0d exp 0/0/1/0/1/0/0",
               add_req, busy, in_ready, out_valid, cfg_ready, out_data, out_region);
    end
    modelClear();
    @(negedge clk);
    rst_n = 1'b1;
    add_ack = 1'b1; add_res = $urandom;
    @(negedge clk);
    add_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || add_req !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("[TB] FAIL late_ack got busy=%b out_valid=%b add_req=%b out_data=%h exp 0/0/0/0",
               busy, out_valid, add_req, out_data);
    end
    run_op(32'h3F800000, 0, 0, 0, 0, 0, 2'd0, 4'd0, '0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cfg_guard();
    test_same_cycle();
    test_out_of_range();
    test_random();
    test_sat_skip();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
